// File: rtl/jtag_tap_gen.sv
// jtag_tap_gen: IEEE 1149.1 TAP with boundary scan, IDCODE, CLAMP/HIGHZ and user data registers
module jtag_tap_gen #(
   parameter int          IR_WIDTH    = 4,
   parameter int          NUM_INPUTS  = 1,
   parameter int          NUM_OUTPUTS = 1,
   parameter int          NUM_USER    = 2,
   parameter int          USER_WIDTH  = 8,
   parameter logic [31:0] DEVICE_ID   = {4'hF, 16'hED, 11'b00001001001, 1'b1}
) (
   input  logic                           TCK,
   input  logic                           TRSTn,
   input  logic                           TMS,
   input  logic                           TDI,
   output logic                           TDO,
   output logic                           tdo_oe,
   input  logic [NUM_INPUTS-1:0]          inputs,
   output logic [NUM_INPUTS-1:0]          to_core,
   input  logic [NUM_OUTPUTS-1:0]         from_core,
   output logic [NUM_OUTPUTS-1:0]         outputs,
   output logic                           outputs_oe,
   input  logic [NUM_USER*USER_WIDTH-1:0] user_capture,
   output logic [NUM_USER*USER_WIDTH-1:0] user_update,
   output logic [NUM_USER-1:0]            user_update_stb
);
   localparam int NB = NUM_INPUTS + NUM_OUTPUTS;

   typedef enum logic [3:0] {
      S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR, S_UPD_DR,
      S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
   } state_t;

   state_t                         r_state;
   logic [IR_WIDTH-1:0]            r_ir_sr, r_ir;
   logic [31:0]                    r_id_sr;
   logic [NB-1:0]                  r_bs_sr, r_bs_upd;
   logic [USER_WIDTH-1:0]          r_usr_sr;
   logic                           r_byp, r_tdo, r_oe;
   logic [NUM_USER*USER_WIDTH-1:0] r_user_upd;
   logic [NUM_USER-1:0]            r_stb;

   logic                  w_id, w_sp, w_ex, w_in, w_cl, w_hz, w_bs, w_usr, w_byp;
   logic                  w_cap, w_shift, w_upd, w_dr_lsb;
   logic [NUM_USER-1:0]   w_uhit;
   logic [USER_WIDTH-1:0] w_ucap;

   assign w_id    = r_ir == IR_WIDTH'(1);
   assign w_sp    = r_ir == IR_WIDTH'(2);
   assign w_ex    = r_ir == IR_WIDTH'(3);
   assign w_in    = r_ir == IR_WIDTH'(4);
   assign w_cl    = r_ir == IR_WIDTH'(5);
   assign w_hz    = r_ir == IR_WIDTH'(6);
   assign w_bs    = w_sp | w_ex | w_in;
   assign w_usr   = |w_uhit;
   assign w_byp   = !(w_id | w_bs | w_usr);
   assign w_cap   = r_state == S_CAP_DR;
   assign w_shift = r_state == S_SHIFT_DR;
   assign w_upd   = r_state == S_UPD_DR;

   // USERk decode and selection of the matching capture slice
   always_comb begin
      w_uhit = '0;
      w_ucap = '0;
      for (int k = 0; k < NUM_USER; k++) begin
         w_uhit[k] = r_ir == IR_WIDTH'(8 + k);
         w_ucap   |= w_uhit[k] ? user_capture[k*USER_WIDTH +: USER_WIDTH] : '0;
      end
   end

   // 16-state TAP controller advanced by TMS on each TCK rise
   always_ff @(posedge TCK or negedge TRSTn)
      if (!TRSTn) r_state <= S_TLR;
      else
         case (r_state)
            S_TLR:      r_state <= TMS ? S_TLR      : S_RTI;
            S_RTI:      r_state <= TMS ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   r_state <= TMS ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   r_state <= TMS ? S_EX1_DR   : S_SHIFT_DR;
            S_SHIFT_DR: r_state <= TMS ? S_EX1_DR   : S_SHIFT_DR;
            S_EX1_DR:   r_state <= TMS ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: r_state <= TMS ? S_EX2_DR   : S_PAUSE_DR;
            S_EX2_DR:   r_state <= TMS ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   r_state <= TMS ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   r_state <= TMS ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   r_state <= TMS ? S_EX1_IR   : S_SHIFT_IR;
            S_SHIFT_IR: r_state <= TMS ? S_EX1_IR   : S_SHIFT_IR;
            S_EX1_IR:   r_state <= TMS ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: r_state <= TMS ? S_EX2_IR   : S_PAUSE_IR;
            S_EX2_IR:   r_state <= TMS ? S_UPD_IR   : S_SHIFT_IR;
            default:    r_state <= TMS ? S_SEL_DR   : S_RTI;
         endcase

   // IR and data shift registers: capture leaving CAP, shift LSB-first with TDI into the MSB
   always_ff @(posedge TCK or negedge TRSTn)
      if (!TRSTn) begin
         r_ir_sr  <= '0;
         r_id_sr  <= '0;
         r_bs_sr  <= '0;
         r_usr_sr <= '0;
         r_byp    <= 1'b0;
      end else begin
         if (r_state == S_CAP_IR) r_ir_sr <= IR_WIDTH'(2'b01);
         else if (r_state == S_SHIFT_IR) r_ir_sr <= IR_WIDTH'({TDI, r_ir_sr} >> 1);
         if ((w_cap | w_shift) && w_id)  r_id_sr  <= w_cap ? DEVICE_ID : {TDI, r_id_sr[31:1]};
         if ((w_cap | w_shift) && w_bs)  r_bs_sr  <= w_cap ? {inputs, from_core} : NB'({TDI, r_bs_sr} >> 1);
         if ((w_cap | w_shift) && w_usr) r_usr_sr <= w_cap ? w_ucap : USER_WIDTH'({TDI, r_usr_sr} >> 1);
         if ((w_cap | w_shift) && w_byp) r_byp    <= !w_cap & TDI;
      end

   // Active instruction: IDCODE after reset or in TLR, new value on the UPD_IR fall
   always_ff @(negedge TCK or negedge TRSTn)
      if (!TRSTn) r_ir <= IR_WIDTH'(1);
      else if (r_state == S_TLR) r_ir <= IR_WIDTH'(1);
      else if (r_state == S_UPD_IR) r_ir <= r_ir_sr;

   // Boundary and user update registers plus one-period user strobes on the UPD_DR fall
   always_ff @(negedge TCK or negedge TRSTn)
      if (!TRSTn) begin
         r_bs_upd   <= '0;
         r_user_upd <= '0;
         r_stb      <= '0;
      end else begin
         if (w_upd && w_bs) r_bs_upd <= r_bs_sr;
         r_stb <= w_upd ? w_uhit : '0;
         for (int k = 0; k < NUM_USER; k++)
            if (w_upd && w_uhit[k]) r_user_upd[k*USER_WIDTH +: USER_WIDTH] <= r_usr_sr;
      end

   assign w_dr_lsb = w_id ? r_id_sr[0] : w_bs ? r_bs_sr[0] : w_usr ? r_usr_sr[0] : r_byp;

   // TDO and its enable change on the TCK fall so the tester samples them on the next rise
   always_ff @(negedge TCK or negedge TRSTn)
      if (!TRSTn) begin
         r_tdo <= 1'b0;
         r_oe  <= 1'b0;
      end else begin
         r_oe  <= (r_state == S_SHIFT_IR) | w_shift;
         r_tdo <= (r_state == S_SHIFT_IR) ? r_ir_sr[0] : w_dr_lsb;
      end

   assign TDO             = r_oe ? r_tdo : 1'bz;
   assign tdo_oe          = r_oe;
   assign to_core         = w_in ? r_bs_upd[NB-1 -: NUM_INPUTS] : inputs;
   assign outputs         = (w_ex | w_in | w_cl) ? r_bs_upd[NUM_OUTPUTS-1:0] : from_core;
   assign outputs_oe      = !w_hz;
   assign user_update     = r_user_upd;
   assign user_update_stb = r_stb;
endmodule

// File: tb/tb_jtag_tap_gen.sv
// tb_jtag_tap_gen: directed-vector bench for the TAP using default parameters
module tb_jtag_tap_gen;
   logic        TCK = 1'b0, TRSTn, TMS, TDI;
   logic        TDO, tdo_oe, outputs_oe;
   logic [0:0]  inputs, to_core, from_core, outputs;
   logic [15:0] user_capture, user_update;
   logic [1:0]  user_update_stb;
   int          errors = 0, checks = 0;
   logic [31:0] q;
   logic [3:0]  irq;
   logic        oe_all;

   jtag_tap_gen dut (
      .TCK(TCK), .TRSTn(TRSTn), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_oe(tdo_oe),
      .inputs(inputs), .to_core(to_core), .from_core(from_core), .outputs(outputs),
      .outputs_oe(outputs_oe), .user_capture(user_capture), .user_update(user_update),
      .user_update_stb(user_update_stb)
   );

   always #5 TCK = ~TCK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one TCK period: drive before the rise, return 1ns after the fall
   task automatic step(input logic tms, input logic tdi = 1'b0);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask

   // RTI -> SHIFT_IR, shift 4 bits, stop in EX1_IR
   task automatic ir_shift(input logic [3:0] d, output logic [3:0] o);
      step(1); step(1); step(0); step(0);
      for (int i = 0; i < 4; i++) begin
         o[i] = TDO;
         step(i == 3, d[i]);
      end
   endtask

   task automatic ir_upd();
      step(1); step(0);
   endtask

   // RTI -> SHIFT_DR, shift n bits, stop in EX1_DR
   task automatic dr_shift(input logic [31:0] d, input int n, output logic [31:0] o, output logic oe);
      step(1); step(0); step(0);
      o  = '0;
      oe = 1'b1;
      for (int i = 0; i < n; i++) begin
         o[i] = TDO;
         oe   = oe & tdo_oe;
         step(i == n - 1, d[i]);
      end
   endtask

   task automatic dr_upd();
      step(1); step(0);
   endtask

   initial begin
      TRSTn = 1'b0; TMS = 1'b1; TDI = 1'b0;
      inputs = 1'b1; from_core = 1'b0; user_capture = 16'h3C5A;
      repeat (2) @(negedge TCK);
      #1;
      chk("rst_tdo_oe", 32'(tdo_oe), 0);
      chk("rst_to_core", 32'(to_core), 1);
      chk("rst_outputs", 32'(outputs), 0);
      chk("rst_outputs_oe", 32'(outputs_oe), 1);
      chk("rst_user_update", 32'(user_update), 0);
      chk("rst_stb", 32'(user_update_stb), 0);
      inputs = 1'b0; from_core = 1'b1; #1;
      chk("rst_to_core_track", 32'(to_core), 0);
      chk("rst_outputs_track", 32'(outputs), 1);
      inputs = 1'b1; from_core = 1'b0;
      TRSTn = 1'b1;
      step(0);
      dr_shift(0, 32, q, oe_all);
      chk("idcode", q, 32'hF00ED093);
      chk("idcode_oe_shift", 32'(oe_all), 1);
      chk("idcode_oe_exit", 32'(tdo_oe), 0);
      dr_upd();
      ir_shift(4'hF, irq);
      chk("ir_capture", 32'(irq), 32'h1);
      ir_upd();
      dr_shift(32'h0A5, 9, q, oe_all);
      chk("bypass", q, 32'h14A);
      dr_upd();
      ir_shift(4'h2, irq);
      ir_upd();
      dr_shift(32'h1, 2, q, oe_all);
      chk("bs_capture", q, 32'h2);
      dr_upd();
      chk("preload_outputs", 32'(outputs), 0);
      ir_shift(4'h3, irq);
      TMS = 1'b1;
      @(posedge TCK);
      #1;
      chk("extest_before_fall", 32'(outputs), 0);
      @(negedge TCK);
      #1;
      chk("extest_after_fall", 32'(outputs), 1);
      step(0);
      inputs = 1'b0; #1;
      chk("extest_to_core0", 32'(to_core), 0);
      inputs = 1'b1; #1;
      chk("extest_to_core1", 32'(to_core), 1);
      ir_shift(4'h6, irq);
      ir_upd();
      chk("highz_oe", 32'(outputs_oe), 0);
      dr_shift(32'h3, 3, q, oe_all);
      chk("highz_len", q, 32'h6);
      dr_upd();
      ir_shift(4'h5, irq);
      ir_upd();
      chk("clamp_oe", 32'(outputs_oe), 1);
      chk("clamp_outputs", 32'(outputs), 1);
      chk("clamp_to_core", 32'(to_core), 1);
      ir_shift(4'h4, irq);
      ir_upd();
      chk("intest_to_core", 32'(to_core), 0);
      chk("intest_outputs", 32'(outputs), 1);
      ir_shift(4'h9, irq);
      ir_upd();
      dr_shift(32'hC3, 8, q, oe_all);
      chk("user1_capture", q, 32'h3C);
      chk("user1_stb_pre", 32'(user_update_stb), 0);
      step(1);
      chk("user1_update", 32'(user_update), 32'hC300);
      chk("user1_stb_on", 32'(user_update_stb), 32'h2);
      step(0);
      chk("user1_stb_off", 32'(user_update_stb), 0);
      chk("user1_hold", 32'(user_update), 32'hC300);
      ir_shift(4'h8, irq);
      ir_upd();
      step(1); step(0); step(1); step(1);
      chk("user0_noshift", 32'(user_update), 32'hC35A);
      chk("user0_stb", 32'(user_update_stb), 32'h1);
      step(0);
      step(1); step(0); step(0);
      step(0, 1'b1); step(0, 1'b1);
      chk("user0_shifting", 32'(tdo_oe), 1);
      TRSTn = 1'b0; #1;
      chk("trst_tdo_oe", 32'(tdo_oe), 0);
      chk("trst_stb", 32'(user_update_stb), 0);
      chk("trst_user_update", 32'(user_update), 0);
      @(negedge TCK);
      #1;
      TRSTn = 1'b1;
      step(1);
      chk("trst_stb_after", 32'(user_update_stb), 0);
      step(0);
      dr_shift(0, 32, q, oe_all);
      chk("trst_idcode", q, 32'hF00ED093);
      dr_upd();
      ir_shift(4'hF, irq);
      ir_upd();
      step(1); step(0); step(0); step(1); step(0);
      chk("pause_oe", 32'(tdo_oe), 0);
      repeat (5) step(1);
      step(0);
      dr_shift(0, 32, q, oe_all);
      chk("tlr_idcode", q, 32'hF00ED093);
      dr_upd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jtag_tap_gen.md
# jtag_tap_gen

Parametrised IEEE 1149.1 test access port with an integrated 16-state TAP controller, configurable instruction-register width, a boundary-scan chain, an ID register and `NUM_USER` user data registers. It sits at the chip pad ring between the JTAG pins and the core. It adds the CLAMP and HIGHZ instructions and user capture/update registers for on-chip debug and configuration. Everything runs in the TCK domain.

## Interface
- `IR_WIDTH`, default 4: instruction register length; ≥4.
- `NUM_INPUTS`, default 1: input boundary cells.
- `NUM_OUTPUTS`, default 1: output boundary cells.
- `NUM_USER`, default 2: user data registers; 0..(2^IR_WIDTH − 9).
- `USER_WIDTH`, default 8: bits per user register; ≥1.
- `DEVICE_ID`, default {4'hF, 16'hED, 11'b00001001001, 1'b1}: 32-bit IDCODE; LSB must be 1.
- `TCK  in  1`: test clock, the only clock.
- `TRSTn  in  1`: asynchronous, active-low reset.
- `TMS  in  1`: mode select, sampled on TCK rise.
- `TDI  in  1`: serial data in, sampled on TCK rise.
- `TDO  out  1`: serial data out; high-Z when not shifting.
- `tdo_oe  out  1`: TDO driver enable, for pad cells without tristate.
- `inputs  in  NUM_INPUTS`: from input pads.
- `to_core  out  NUM_INPUTS`: to core logic.
- `from_core  in  NUM_OUTPUTS`: core output values.
- `outputs  out  NUM_OUTPUTS`: to output pads.
- `outputs_oe  out  1`: output pad enable; 0 under HIGHZ.
- `user_capture  in  NUM_USER*USER_WIDTH`: parallel capture values; register k is slice k.
- `user_update  out  NUM_USER*USER_WIDTH`: latched user register values.
- `user_update_stb  out  NUM_USER`: per-register update strobe.

## Operation
- **Controller:** standard 16-state FSM: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR, and the matching IR states.
  - Transitions are per 1149.1 on each TCK rise, driven by TMS.
  - Five consecutive TMS=1 rises reach TLR from any state.
- **Instruction codes** (zero-extended to `IR_WIDTH`):
  - IDCODE=1, SAMPLE_PRELOAD=2, EXTEST=3, INTEST=4, CLAMP=5, HIGHZ=6, USERk=8+k.
  - All-ones is BYPASS. Every unlisted code, including all zeros, behaves as BYPASS.
- **IR shift register:** loads {0…0, 2'b01} in CAP_IR. Shifts LSB-first from TDI in SHIFT_IR.
- **IR update register:** loads from the shift register on the TCK fall in UPD_IR. It is forced to IDCODE asynchronously by TRSTn=0 and synchronously while in TLR.
- **Data register selected by the active instruction:**
  - IDCODE: 32-bit ID register; captures `DEVICE_ID`.
  - SAMPLE_PRELOAD, EXTEST, INTEST: boundary chain {inputs, from_core}; captures the live values.
  - USERk: USER_WIDTH register; captures slice k of `user_capture`.
  - CLAMP, HIGHZ, BYPASS: 1-bit bypass register; captures 0.
- **Data register rules:**
  - Capture happens on the rise leaving CAP_DR.
  - Shifting is LSB-first, TDI entering the MSB, on each rise while in SHIFT_DR.
  - Unselected registers hold their value.
- **Boundary update register:** loads from the BS shift register on the TCK fall in UPD_DR, only for SAMPLE_PRELOAD, EXTEST and INTEST.
- **Pad and core muxing:**
  - `to_core` = BS update input bits under INTEST; otherwise `inputs`.
  - `outputs` = BS update output bits under EXTEST, INTEST or CLAMP; otherwise `from_core`.
  - `outputs_oe` = 0 only under HIGHZ.
- **User update:** on the TCK fall in UPD_DR with USERk active, slice k of `user_update` loads the user shift register. `user_update_stb[k]` is high from that fall until the next TCK fall.
- **TDO and tdo_oe:**
  - Both are registered on the TCK fall.
  - TDO takes the IR LSB in SHIFT_IR, or the selected DR LSB in SHIFT_DR.
  - tdo_oe is 1 only when the state was SHIFT_IR or SHIFT_DR.

## Timing
- **Reset values** (TRSTn=0, asynchronous):
  - state TLR, IR = IDCODE, TDO = Z, `tdo_oe` = 0.
  - `to_core` = `inputs`, `outputs` = `from_core`, `outputs_oe` = 1.
  - `user_update` = 0, `user_update_stb` = 0, BS update register = 0.
- **TRSTn asserted mid-shift:** in-progress shift contents are discarded and no update occurs.
- **Instruction effect:** a new instruction affects the pads from the UPD_IR falling edge, i.e. half a TCK after the UPD_IR rise.
- **TDO first bit:** the first bit shifted out appears on TDO at the fall following the CAP→SHIFT rise.
- **Pause states:** passing through PAUSE/EX2 preserves shift contents.
- **Exit without update:** EX1→UPD without further shifting updates with the captured value.

## Test plan
- **Reset read-out:** pulse TRSTn, go to SHIFT_DR, shift 32 bits → TDO yields `DEVICE_ID` LSB-first (first bit 1) with `tdo_oe`=1 only while shifting.
- **IR capture and BYPASS:** load IR all-ones while reading the IR capture, then shift 8'hA5 through DR → the IR read-out is 4'b0001, and TDO returns 0 followed by 8'hA5 delayed by one cycle.
- **EXTEST:** SAMPLE_PRELOAD preload output bits 1, then EXTEST → `outputs`=1 regardless of `from_core` from the UPD_IR fall, and `to_core` still tracks `inputs`.
- **HIGHZ and CLAMP:** HIGHZ → `outputs_oe`=0 and DR length is 1. Then CLAMP → `outputs_oe`=1 and `outputs` equals the preloaded value.
- **USER1 (USER_WIDTH=8):** `user_capture` slice1=8'h3C; shift in 8'hC3 → TDO returns 8'h3C, `user_update` slice1=8'hC3, `user_update_stb[1]` high for exactly one TCK period, slice0 unchanged.
- **Reset paths:**
  - TRSTn low during SHIFT_DR of USER0 → state TLR and no strobe.
  - Separately, five TMS=1 from PAUSE_DR → TLR and IR=IDCODE.
